// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with a bounded tenure per grantee.
// A requester keeps its grant while it holds its request, for at most
// MAX_HOLD cycles. When a tenure ends, the search pointer moves one past the
// releasing requester and a new winner is picked in the same cycle, so there
// is no idle cycle between back-to-back grants.
//
// state | meaning
// IDLE  | no grant active, waiting for any request
// BUSY  | one requester holds the grant, hold_cnt counts its tenure
module rr_grant_arbiter #(
    parameter int ENCODE_WIDTH = 2,
    parameter int NUM_REQ      = 2 ** ENCODE_WIDTH,
    parameter int MAX_HOLD     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    output logic [NUM_REQ-1:0]      grant,
    output logic [ENCODE_WIDTH-1:0] grant_idx,
    output logic                    grant_valid,
    output logic                    hold_expired
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // MAX_HOLD is limited to 1..255, so an 8-bit tenure counter always fits.
    localparam logic [7:0] MAX_CNT = 8'(MAX_HOLD);

    state_t                  state_q, state_d;
    logic [ENCODE_WIDTH-1:0] idx_q, idx_d;
    logic [ENCODE_WIDTH-1:0] ptr_q, ptr_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    exp_q, exp_d;
    logic [ENCODE_WIDTH-1:0] next_ptr;

    // First set request bit searching upward from p, wrapping modulo NUM_REQ.
    // The loop runs from the farthest offset down, so the nearest hit wins.
    function automatic logic [ENCODE_WIDTH-1:0] pick(
        input logic [NUM_REQ-1:0]      r,
        input logic [ENCODE_WIDTH-1:0] p
    );
        logic [ENCODE_WIDTH-1:0] cand;
        pick = p;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = p + ENCODE_WIDTH'(i);
            if (r[cand]) pick = cand;
        end
    endfunction

    // Pointer value used on release: one past the current grantee.
    assign next_ptr = idx_q + ENCODE_WIDTH'(1);

    // State, grantee, pointer, tenure counter and expiry pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
        end
    end

    // Next-state: start, continue, or release-and-rearbitrate a tenure.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        exp_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BUSY;
                    idx_d   = pick(req, ptr_q);
                    cnt_d   = 8'd1;
                end
            end
            BUSY: begin
                if (req[idx_q] && (cnt_q < MAX_CNT)) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    // Still requesting here means the tenure was cut off.
                    exp_d = req[idx_q];
                    ptr_d = next_ptr;
                    if (|req) begin
                        idx_d = pick(req, next_ptr);
                        cnt_d = 8'd1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded straight from registers, so they move only on
    // clock edges or on reset.
    always_comb begin
        grant = '0;
        if (state_q == BUSY) grant[idx_q] = 1'b1;
    end

    assign grant_valid  = (state_q == BUSY);
    assign grant_idx    = idx_q;
    assign hold_expired = exp_q;

endmodule

// File: doc/rr_grant_arbiter.md
RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

Interface
REQ-001 The block SHALL have parameter ENCODE_WIDTH, default 2, giving the width of the encoded grant index.
REQ-002 The block SHALL have parameter NUM_REQ, fixed at 2**ENCODE_WIDTH (default 4), giving the requester count.
REQ-003 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive grant cycles per tenure (legal range 1..255).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1 bit: the asynchronous, active-high reset.
REQ-007 The block SHALL have port req, input, NUM_REQ bits: per-requester level requests, bit i for requester i.
REQ-008 The block SHALL have port grant, output, NUM_REQ bits: registered one-hot grant, or all zero.
REQ-009 The block SHALL have port grant_idx, output, ENCODE_WIDTH bits: encoded index of the current grantee.
REQ-010 The block SHALL have port grant_valid, output, 1 bit: high while any grant is active.
REQ-011 The block SHALL have port hold_expired, output, 1 bit: one-cycle pulse when a tenure is cut off at MAX_HOLD.

Function
REQ-012 The block SHALL implement exactly two states: IDLE (no grant) and BUSY (one grant active).
REQ-013 grant SHALL equal the one-hot decode of grant_idx when grant_valid=1, and SHALL be all zero when grant_valid=0.
REQ-014 The block SHALL keep a round-robin pointer ptr (ENCODE_WIDTH bits); the arbitration winner is the first set req bit searching ptr, ptr+1, ... with wrap modulo NUM_REQ.
REQ-015 In IDLE with req!=0 at a clock edge, the block SHALL enter BUSY with grant_idx=winner and hold_cnt=1, so latency from req to grant is 1 cycle.
REQ-016 In IDLE with req==0, the block SHALL remain in IDLE, with ptr unchanged.
REQ-017 In BUSY, the tenure SHALL continue while req[grant_idx]=1 and hold_cnt<MAX_HOLD; hold_cnt SHALL increment by 1 per cycle and saturate at MAX_HOLD.
REQ-018 A tenure SHALL end (release) when req[grant_idx]=0, or when hold_cnt==MAX_HOLD and req[grant_idx]=1 (expiry).
REQ-019 On release, ptr SHALL become (grant_idx+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-020 On release, arbitration SHALL use the new ptr in the same cycle; if any req is set (including the releasing requester under expiry), the next grant SHALL start at the next edge with no idle bubble; otherwise the state SHALL go to IDLE.
REQ-021 Under expiry, the expired requester SHALL be eligible again but lowest priority; with NUM_REQ other requests absent, it is re-granted with a fresh hold_cnt=1.
REQ-022 hold_expired SHALL be registered and high for exactly the one cycle following an expiry edge, and low otherwise.
REQ-023 Changes in req bits other than req[grant_idx] SHALL NOT affect an active tenure.
REQ-024 At most one grant bit SHALL be high in any cycle, and grant SHALL change only on clock edges.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, grant=0, grant_idx=0, grant_valid=0, hold_expired=0, ptr=0 and hold_cnt=0.
REQ-026 Reset asserted mid-tenure SHALL drop the grant asynchronously, and the first arbitration after rst deasserts SHALL restart from ptr=0.
REQ-027 While rst=1, req SHALL be ignored.

Verification (NUM_REQ=4, MAX_HOLD=8)
REQ-028 After reset, set req=4'b1010 -> 1 cycle later grant=4'b0010, grant_idx=1 and grant_valid=1; then drop req[1] -> next cycle grant=4'b1000, grant_idx=3, with no bubble.
REQ-029 Hold req=4'b1111 constantly -> grants rotate in the order 0,1,2,3,0, each lasting 8 cycles, with hold_expired pulsing 1 cycle after each 8-cycle tenure.
REQ-030 Hold only req[2]=1 for 20 cycles -> tenures of 8, 8 and 4 cycles to requester 2 with no gaps; hold_expired pulses twice.
REQ-031 Grant requester 3, then release it with req=4'b0001 -> ptr wraps to 0 and grant=4'b0001.
REQ-032 Assert rst while grant=4'b0100 -> grant=0 and grant_valid=0 before the next clock edge; after release with req=4'b0110 -> grant_idx=1.
REQ-033 Sweep all 16 req values from IDLE with ptr=0 -> grant_idx is the lowest set bit, grant is its one-hot decode, and req=0 keeps grant_valid=0.
